// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous value commit.
// Optional leading-zero suppression is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp_en,
  input  logic        ld,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - BLANK_CYC - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    digit, digit_nxt;
  logic [15:0]   disp, pend;
  logic [3:0]    disp_dp, pend_dp;
  logic          pend_v;
  logic          boundary;
  logic [3:0]    nib;
  logic [7:0]    dec;
  logic [7:0]    seg_nxt;
  logic [3:0]    an_nxt;
`ifdef SSEG_LZ_BLANK_EN
  logic          lz;
`endif

  function automatic logic [7:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 8'h03;  4'h1: hex7 = 8'h9F;  4'h2: hex7 = 8'h25;  4'h3: hex7 = 8'h0D;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h49;  4'h6: hex7 = 8'h41;  4'h7: hex7 = 8'h1F;
      4'h8: hex7 = 8'h01;  4'h9: hex7 = 8'h19;  4'hA: hex7 = 8'h11;  4'hB: hex7 = 8'hC1;
      4'hC: hex7 = 8'h63;  4'hD: hex7 = 8'h85;  4'hE: hex7 = 8'h61;  default: hex7 = 8'h71;
    endcase
  endfunction

  // Slot sequencing plus the next values of the registered pin outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    digit_nxt = digit;
    boundary  = 1'b0;
    case (state)
      BLANK: if (cnt == BLANK_LAST) begin
        state_nxt = DRIVE;
        cnt_nxt   = '0;
      end
      default: if (cnt == DRIVE_LAST) begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
        digit_nxt = digit + 2'd1;
        boundary  = (digit == 2'd3);
      end
    endcase

    nib     = disp[{digit, 2'b00} +: 4];
    dec     = hex7(nib);
    an_nxt  = 4'b1111;
    seg_nxt = 8'hFF;
`ifdef SSEG_LZ_BLANK_EN
    case (digit)
      2'd3:    lz = (disp[15:12] == 4'h0);
      2'd2:    lz = (disp[15:8] == 8'h00);
      2'd1:    lz = (disp[15:4] == 12'h000);
      default: lz = 1'b0;
    endcase
`endif
    if (state == DRIVE) begin
      an_nxt  = ~(4'b0001 << digit);
      seg_nxt = {dec[7:1], ~disp_dp[digit]};
`ifdef SSEG_LZ_BLANK_EN
      if (lz) seg_nxt[7:1] = 7'h7F;
`endif
    end
  end

  // A load on the boundary cycle becomes the new pending value; the commit takes the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BLANK;
      cnt     <= '0;
      digit   <= 2'd0;
      disp    <= 16'h0000;
      disp_dp <= 4'h0;
      pend    <= 16'h0000;
      pend_dp <= 4'h0;
      pend_v  <= 1'b0;
      an      <= 4'b1111;
      seg     <= 8'hFF;
      frame   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      digit <= digit_nxt;
      an    <= an_nxt;
      seg   <= seg_nxt;
      frame <= boundary;
      if (boundary && pend_v) begin
        disp    <= pend;
        disp_dp <= pend_dp;
      end
      if (ld) begin
        pend    <= data;
        pend_dp <= dp_en;
        pend_v  <= 1'b1;
      end else if (boundary) begin
        pend_v  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (CLK_DIV=8, BLANK_CYC=2) against a frame-position model.
// Expectations follow SSEG_LZ_BLANK_EN when it is defined for the build.
module tb_sseg_scan_ctrl;

  localparam int CD   = 8;
  localparam int BC   = 2;
  localparam int FRM  = 4 * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp_en;
  logic        ld;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  int checks = 0;
  int errors = 0;

  sseg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_en(dp_en), .ld(ld),
    .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Expected segment pattern for digit d of value v, straight from the decode table.
  function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [3:0] dp, input int d);
    logic [7:0]  s;
    logic [15:0] upper;
    upper = v >> (4 * d);
    s = hex_tab[upper & 16'hF];
`ifdef SSEG_LZ_BLANK_EN
    if (d != 0 && upper == 16'h0000) s = 8'hFF;
`endif
    s[0] = ~dp[d];
    return s;
  endfunction

  // Model: position within the frame is just cycles-since-reset modulo the frame length.
  int          k;
  int          m_pos, m_slot, m_off;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pv;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_frame;

  assign m_pos  = k % FRM;
  assign m_slot = m_pos / CD;
  assign m_off  = m_pos % CD;

  always @(posedge clk) begin
    if (rst) begin
      k <= 0; m_disp <= 16'h0; m_dp <= 4'h0; m_pv <= 1'b0;
      exp_an <= 4'hF; exp_seg <= 8'hFF; exp_frame <= 1'b0;
    end else begin
      exp_an    <= (m_off < BC) ? 4'hF : ~(4'b0001 << m_slot);
      exp_seg   <= (m_off < BC) ? 8'hFF : ref_seg(m_disp, m_dp, m_slot);
      exp_frame <= (m_pos == FRM - 1);
      if (m_pos == FRM - 1 && m_pv) begin
        m_disp <= m_pend; m_dp <= m_pdp;
      end
      if (ld) begin
        m_pend <= data; m_pdp <= dp_en; m_pv <= 1'b1;
      end else if (m_pos == FRM - 1) begin
        m_pv <= 1'b0;
      end
      k <= k + 1;
    end
  end

  task automatic align(input int r);
    int n = 0;
    while (m_pos != r && n < 4 * FRM) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_ld(input logic [15:0] v, input logic [3:0] dp);
    data = v; dp_en = dp; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Captures one whole frame of displayed digits starting at frame position 1.
  task automatic grab_frame(output logic [3:0][7:0] g);
    g = '1;
    align(1);
    for (int i = 0; i < FRM; i++) begin
      for (int d = 0; d < 4; d++) if (an[d] === 1'b0) g[d] = seg;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b0; data = 16'h0; dp_en = 4'h0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || seg !== 8'hFF || frame !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold: an=%b seg=%h frame=%b required an=1111 seg=ff frame=0", an, seg, frame);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (c < 3 && an !== 4'hF) begin
        errors++;
        $display("[TB] FAIL reset_release_blank c=%0d: an=%b required 1111", c, an);
      end else if (c == 3 && (an !== 4'b1110 || seg !== 8'h03)) begin
        errors++;
        $display("[TB] FAIL reset_release_first: an=%b seg=%h required an=1110 seg=03", an, seg);
      end
    end
  endtask

  task automatic test_scan();
    int last_f = -1;
    int nframes = 0;
    for (int i = 0; i < 3 * FRM + 4; i++) begin
      @(negedge clk);
      checks += 3;
      if (an !== exp_an) begin
        errors++; $display("[TB] FAIL scan_an k=%0d: an=%b required %b", k, an, exp_an);
      end
      if (seg !== exp_seg) begin
        errors++; $display("[TB] FAIL scan_seg k=%0d: seg=%h required %h", k, seg, exp_seg);
      end
      if ($countones(~an) > 1) begin
        errors++; $display("[TB] FAIL scan_onehot k=%0d: an=%b required at most one low", k, an);
      end
      if (frame === 1'b1) begin
        nframes++;
        if (last_f >= 0) begin
          checks++;
          if (k - last_f != FRM) begin
            errors++; $display("[TB] FAIL frame_period: got %0d required %0d", k - last_f, FRM);
          end
        end
        last_f = k;
      end
    end
    checks++;
    if (nframes < 3) begin
      errors++; $display("[TB] FAIL frame_count: got %0d required >=3", nframes);
    end
  endtask

  task automatic test_load_commit();
    logic [3:0][7:0] g;
    logic [7:0] old3 = 8'hFF;
    align(5);
    pulse_ld(16'h12AF, 4'b0100);
    while (m_pos != 0) begin
      if (an[3] === 1'b0) old3 = seg;
      @(negedge clk);
    end
`ifdef SSEG_LZ_BLANK_EN
    checks++;
    if (old3 !== 8'hFF) begin
      errors++; $display("[TB] FAIL load_old_persists: digit3=%h required ff", old3);
    end
`else
    checks++;
    if (old3 !== 8'h03) begin
      errors++; $display("[TB] FAIL load_old_persists: digit3=%h required 03", old3);
    end
`endif
    grab_frame(g);
    checks++;
    if (g !== {8'h9F, 8'h24, 8'h11, 8'h71}) begin
      errors++; $display("[TB] FAIL load_commit: digits3..0=%h required 9f241171", g);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][7:0] g;
    align(3);
    pulse_ld(16'h1111, 4'h0);
    align(8);
    pulse_ld(16'h2222, 4'h0);
    grab_frame(g);
    checks++;
    if (g !== {8'h25, 8'h25, 8'h25, 8'h25}) begin
      errors++; $display("[TB] FAIL last_wins: digits=%h required 25252525", g);
    end
    align(FRM - 1);
    pulse_ld(16'h3333, 4'h0);
    grab_frame(g);
    checks++;
    if (g[0] !== 8'h25) begin
      errors++; $display("[TB] FAIL boundary_ld_wait: digit0=%h required 25", g[0]);
    end
    grab_frame(g);
    checks++;
    if (g !== {8'h0D, 8'h0D, 8'h0D, 8'h0D}) begin
      errors++; $display("[TB] FAIL boundary_ld_show: digits=%h required 0d0d0d0d", g);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][7:0] g;
    logic [7:0] lead;
`ifdef SSEG_LZ_BLANK_EN
    lead = 8'hFF;
`else
    lead = 8'h03;
`endif
    align(4);
    pulse_ld(16'hBEEF, 4'hF);
    align(10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      grab_frame(g);
      checks++;
      if (g !== {lead, lead, lead, 8'h03}) begin
        errors++; $display("[TB] FAIL reset_mid f=%0d: digits=%h required %h%h%h03", f, g, lead, lead, lead);
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0][7:0] g;
    logic [7:0] lead;
`ifdef SSEG_LZ_BLANK_EN
    lead = 8'hFF;
`else
    lead = 8'h03;
`endif
    align(3);
    pulse_ld(16'h0040, 4'h0);
    grab_frame(g);
    checks++;
    if (g !== {lead, lead, 8'h99, 8'h03}) begin
      errors++; $display("[TB] FAIL leading_zero: digits=%h required %h%h9903", g, lead, lead);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks += 3;
      if (an !== exp_an) begin
        errors++; $display("[TB] FAIL rand_an k=%0d: an=%b required %b", k, an, exp_an);
      end
      if (seg !== exp_seg) begin
        errors++; $display("[TB] FAIL rand_seg k=%0d: seg=%h required %h", k, seg, exp_seg);
      end
      if (frame !== exp_frame) begin
        errors++; $display("[TB] FAIL rand_frame k=%0d: frame=%b required %b", k, frame, exp_frame);
      end
      data  = 16'($urandom);
      dp_en = 4'($urandom);
      ld    = ($urandom_range(0, 11) == 0);
      rst   = ($urandom_range(0, 249) == 0);
    end
    rst = 1'b0; ld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_commit();
    test_back_to_back();
    test_reset_mid();
    test_lz();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
